seq_shifter: RTL and testbench



---
 rtl/seq_shifter.sv | 52 +++++
 tb/tb_seq_shifter.sv | 134 +++++++++++++
 2 files changed

// File: rtl/seq_shifter.sv
// seq_shifter: multi-cycle 16-bit shift/rotate engine, one bit per clock under valid/ready handshakes
module seq_shifter (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] In,
  input  logic [3:0]  Cnt,
  input  logic [1:0]  Op,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] Out,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE = 2'b00, SHIFT = 2'b01, DONE = 2'b10} state_t;
  state_t state, next;
  logic [15:0] data, step;
  logic [3:0] count;
  logic [1:0] op;
  always_comb begin
    next = IDLE;
    step = data;
    next = state == IDLE  ? (in_valid ? (Cnt != 4'd0 ? SHIFT : DONE) : IDLE) :
           state == SHIFT ? (count == 4'd1 ? DONE : SHIFT) :
           state == DONE  ? (out_ready ? IDLE : DONE) : IDLE;
    step = op == 2'b00 ? {data[14:0], data[15]} :
           op == 2'b01 ? {data[14:0], 1'b0} :
           op == 2'b10 ? {data[0], data[15:1]} : {1'b0, data[15:1]};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      data  <= 16'h0000;
      count <= 4'd0;
      op    <= 2'b00;
    end else begin
      state <= next;
      if (state == IDLE && in_valid) begin
        data  <= In;
        count <= Cnt;
        op    <= Op;
      end else if (state == SHIFT) begin
        data  <= step;
        count <= count - 4'd1;
      end
    end
  end
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign busy      = state == SHIFT || state == DONE;
  assign Out       = data;
endmodule

// File: tb/tb_seq_shifter.sv
// tb_seq_shifter: random and directed transactions checked against an arithmetic shift/rotate model
module tb_seq_shifter;
  logic clk = 1'b0;
  logic rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid, busy;
  logic [15:0] din = 16'h0, out;
  logic [3:0] cnt = 4'd0;
  logic [1:0] op = 2'b00;
  int checks = 0, errors = 0;

  seq_shifter dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .In(din), .Cnt(cnt), .Op(op), .out_valid(out_valid),
    .out_ready(out_ready), .Out(out), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model(input logic [15:0] x, input logic [1:0] o, input int n);
    logic [31:0] w, r;
    w = {16'h0, x};
    case (o)
      2'b00: r = (w << n) | (w >> (16 - n));
      2'b01: r = w << n;
      2'b10: r = (w >> n) | (w << (16 - n));
      default: r = w >> n;
    endcase
    return r[15:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic xact(input logic [15:0] x, input logic [1:0] o, input logic [3:0] n,
                      input int stall, input bit pulses);
    int lat, guard;
    logic [15:0] held;
    guard = 0;
    while (!in_ready && guard < 50) begin
      tick();
      guard++;
    end
    check("in_ready_idle", in_ready, 1);
    check("busy_idle", busy, 0);
    din = x; op = o; cnt = n; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    din = 16'($urandom); op = 2'($urandom); cnt = 4'($urandom);
    lat = 1;
    while (!out_valid && lat < 40) begin
      check("in_ready_shift", in_ready, 0);
      check("busy_shift", busy, 1);
      tick();
      lat++;
    end
    check("latency", lat, int'(n) + 1);
    check("result", out, model(x, o, int'(n)));
    check("busy_done", busy, 1);
    held = out;
    for (int i = 0; i < stall; i++) begin
      in_valid = pulses ? 1'($urandom_range(0, 1)) : 1'b0;
      din = 16'($urandom); cnt = 4'($urandom);
      tick();
      check("hold_out", out, held);
      check("hold_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("drain_in_ready", in_ready, 1);
    check("drain_out_valid", out_valid, 0);
  endtask

  initial begin
    tick();
    tick();
    rst = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out", out, 16'h0000);

    xact(16'h8001, 2'b00, 4'd4, 0, 0);
    check("rotl_known", model(16'h8001, 2'b00, 4), 16'h0018);
    xact(16'h8001, 2'b01, 4'd4, 0, 0);
    xact(16'h0001, 2'b10, 4'd1, 0, 0);
    xact(16'h8000, 2'b11, 4'd15, 0, 0);
    xact(16'h8001, 2'b00, 4'd15, 1, 0);
    for (int o = 0; o < 4; o++) xact(16'hA5A5, 2'(o), 4'd0, 0, 0);
    xact(16'h1234, 2'b10, 4'd3, 10, 1);
    xact(16'hF00F, 2'b01, 4'd2, 0, 0);

    din = 16'h1234; op = 2'b00; cnt = 4'd10; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    check("mid_busy", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_out", out, 16'h0000);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("no_stale", out_valid, 0);
    end

    for (int t = 0; t < 1000; t++)
      xact(16'($urandom), 2'($urandom), 4'($urandom), int'($urandom_range(0, 3)), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
